// File: rtl/text_console_ctrl.sv
// text_console_ctrl: keyboard-driven writer for a COLS x 2^RW character buffer.
// Tracks the cursor, scrolls by rotating line_offset, and clears rows/screen
// one buffer word per cycle.
module text_console_ctrl #(
   parameter int COLS = 70,
   parameter int ROWS = 30,
   parameter int CW   = 7,
   parameter int RW   = 5,
   parameter int TAB  = 4
) (
   input  logic             clk_50m,
   input  logic             BTNC,
   input  logic             key_valid,
   input  logic [7:0]       key_char,
   output logic             key_ready,
   output logic             wr_en,
   output logic [CW+RW-1:0] wr_addr,
   output logic [7:0]       wr_data,
   output logic [CW-1:0]    h_cur,
   output logic [RW-1:0]    v_cur,
   output logic [RW-1:0]    line_offset
);

   localparam int unsigned   DEPTH     = 2**RW;
   localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
   localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
   localparam logic [RW-1:0] LAST_PHYS = '1;
   localparam logic [CW-1:0] TAB_MASK  = CW'(TAB - 1);

   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_TAB   = 8'h09;
   localparam logic [7:0] CH_CLEAR = 8'h0C;
   localparam logic [7:0] CH_ENTER = 8'h0D;

   typedef enum logic [1:0] {IDLE, EXEC, CLR_ROW, CLR_ALL} state_t;

   state_t        state;
   logic          boot_clear;
   logic [7:0]    cmd;
   logic [CW-1:0] clr_col;
   logic [RW-1:0] clr_row;
   logic [CW-1:0] line_end [DEPTH];

   logic [RW-1:0] cur_prow;
   logic [RW-1:0] prev_prow;
   logic [RW-1:0] next_prow;
   logic [CW-1:0] h_inc;
   logic [CW-1:0] bs_col;
   logic [RW-1:0] bs_v;
   logic [RW-1:0] bs_prow;
   logic          nl_req;
   logic [CW-1:0] nl_end;
   logic          tab_more;

   // Physical rows around the cursor; all row arithmetic wraps at 2^RW.
   always_comb begin
      cur_prow  = v_cur + line_offset;
      prev_prow = cur_prow - RW'(1);
      next_prow = cur_prow + RW'(1);
      h_inc     = h_cur + CW'(1);
   end

   // Backspace target: step left, else jump to the end of the previous line, else stay at (0,0).
   always_comb begin
      bs_col  = h_cur;
      bs_v    = v_cur;
      bs_prow = cur_prow;
      if (h_cur != '0) begin
         bs_col = h_cur - CW'(1);
      end else if (v_cur != '0) begin
         bs_v    = v_cur - RW'(1);
         bs_prow = prev_prow;
         bs_col  = line_end[prev_prow];
      end
   end

   // Newline / tab-continuation decode for the EXEC cycle of enter, printable and tab.
   always_comb begin
      nl_req = 1'b0;
      nl_end = LAST_COL;
      if (cmd == CH_ENTER) begin
         nl_req = 1'b1;
         nl_end = h_cur;
      end else if (h_cur == LAST_COL) begin
         nl_req = 1'b1;
      end
      tab_more = (cmd == CH_TAB) && ((h_inc & TAB_MASK) != '0);
   end

   // Controller: outputs are registered one edge ahead so each write lines up with
   // the state cycle that owns it. Tab fill re-runs EXEC once per filled column.
   always_ff @(posedge clk_50m) begin
      if (BTNC) begin
         state       <= IDLE;
         boot_clear  <= 1'b1;
         cmd         <= '0;
         clr_col     <= '0;
         clr_row     <= '0;
         h_cur       <= '0;
         v_cur       <= '0;
         line_offset <= '0;
         key_ready   <= 1'b0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE: begin
               if (boot_clear) begin
                  boot_clear <= 1'b0;
                  state      <= CLR_ALL;
                  clr_col    <= '0;
                  clr_row    <= '0;
                  wr_en      <= 1'b1;
                  wr_addr    <= '0;
                  wr_data    <= '0;
               end else if (key_valid && key_ready) begin
                  cmd       <= key_char;
                  key_ready <= 1'b0;
                  state     <= EXEC;
                  case (key_char)
                     CH_ENTER, CH_CLEAR: begin
                     end
                     CH_BS: begin
                        wr_en   <= 1'b1;
                        wr_addr <= {bs_col, bs_prow};
                        wr_data <= '0;
                     end
                     CH_TAB: begin
                        wr_en   <= 1'b1;
                        wr_addr <= {h_cur, cur_prow};
                        wr_data <= '0;
                     end
                     default: begin
                        wr_en   <= 1'b1;
                        wr_addr <= {h_cur, cur_prow};
                        wr_data <= key_char;
                     end
                  endcase
               end
            end

            EXEC: begin
               if (cmd == CH_CLEAR) begin
                  state   <= CLR_ALL;
                  clr_col <= '0;
                  clr_row <= '0;
                  wr_en   <= 1'b1;
                  wr_addr <= '0;
                  wr_data <= '0;
               end else if (cmd == CH_BS) begin
                  h_cur     <= bs_col;
                  v_cur     <= bs_v;
                  state     <= IDLE;
                  key_ready <= 1'b1;
               end else if (nl_req) begin
                  line_end[cur_prow] <= nl_end;
                  h_cur              <= '0;
                  if (v_cur < LAST_ROW) begin
                     v_cur     <= v_cur + RW'(1);
                     state     <= IDLE;
                     key_ready <= 1'b1;
                  end else begin
                     // Scroll: the row below the cursor becomes the new bottom row.
                     line_offset         <= line_offset + RW'(1);
                     line_end[next_prow] <= '0;
                     state               <= CLR_ROW;
                     clr_col             <= '0;
                     wr_en               <= 1'b1;
                     wr_addr             <= {{CW{1'b0}}, next_prow};
                     wr_data             <= '0;
                  end
               end else if (tab_more) begin
                  h_cur   <= h_inc;
                  wr_en   <= 1'b1;
                  wr_addr <= {h_inc, cur_prow};
                  wr_data <= '0;
               end else begin
                  h_cur     <= h_inc;
                  state     <= IDLE;
                  key_ready <= 1'b1;
               end
            end

            CLR_ROW: begin
               if (clr_col == LAST_COL) begin
                  state     <= IDLE;
                  key_ready <= 1'b1;
               end else begin
                  clr_col <= clr_col + CW'(1);
                  wr_en   <= 1'b1;
                  wr_addr <= {clr_col + CW'(1), cur_prow};
                  wr_data <= '0;
               end
            end

            CLR_ALL: begin
               // line_end is zeroed row by row as the sweep finishes each row.
               if (clr_col == LAST_COL) begin
                  line_end[clr_row] <= '0;
               end
               if (clr_col == LAST_COL && clr_row == LAST_PHYS) begin
                  h_cur       <= '0;
                  v_cur       <= '0;
                  line_offset <= '0;
                  state       <= IDLE;
                  key_ready   <= 1'b1;
               end else if (clr_col == LAST_COL) begin
                  clr_col <= '0;
                  clr_row <= clr_row + RW'(1);
                  wr_en   <= 1'b1;
                  wr_addr <= {{CW{1'b0}}, clr_row + RW'(1)};
                  wr_data <= '0;
               end else begin
                  clr_col <= clr_col + CW'(1);
                  wr_en   <= 1'b1;
                  wr_addr <= {clr_col + CW'(1), clr_row};
                  wr_data <= '0;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Testbench for text_console_ctrl: hand-computed vector table, directed
// scroll/reset sequences, and random keystrokes checked against a cursor model.
module tb_text_console_ctrl;

   localparam int COLS  = 70;
   localparam int ROWS  = 30;
   localparam int CW    = 7;
   localparam int RW    = 5;
   localparam int TAB   = 4;
   localparam int DEPTH = 1 << RW;
   localparam int NCLR  = COLS * DEPTH;

   logic             clk_50m = 1'b0;
   logic             BTNC = 1'b1;
   logic             key_valid = 1'b0;
   logic [7:0]       key_char = 8'h00;
   logic             key_ready;
   logic             wr_en;
   logic [CW+RW-1:0] wr_addr;
   logic [7:0]       wr_data;
   logic [CW-1:0]    h_cur;
   logic [RW-1:0]    v_cur;
   logic [RW-1:0]    line_offset;

   text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .CW(CW), .RW(RW), .TAB(TAB)) dut (
      .clk_50m(clk_50m), .BTNC(BTNC), .key_valid(key_valid), .key_char(key_char),
      .key_ready(key_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .h_cur(h_cur), .v_cur(v_cur), .line_offset(line_offset)
   );

   always #10 clk_50m = ~clk_50m;

   int checks = 0;
   int failures = 0;
   int gq[$];           // observed writes: addr*256 + data
   int eq[$];           // expected writes
   int last_cyc;

   // Reference model: cursor, offset and per-physical-row line ends.
   int mh, mv, moff;
   int mle[DEPTH];

   typedef struct {
      logic [7:0] ch;
      int h; int v; int off; int nw;
      int lcol; int lrow; int ldata;
   } vec_t;
   vec_t vecs[16];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int wcode(input int col, input int row, input int d);
      return ((col << RW) | row) * 256 + d;
   endfunction

   function automatic void m_wr(input int col, input int row, input int d);
      eq.push_back(wcode(col, row, d));
   endfunction

   function automatic void m_newline();
      int nrow;
      if (mv < ROWS - 1) begin
         mv++;
      end else begin
         moff = (moff + 1) % DEPTH;
         nrow = (mv + moff) % DEPTH;
         mle[nrow] = 0;
         for (int col = 0; col < COLS; col++) m_wr(col, nrow, 0);
      end
   endfunction

   function automatic void m_clear();
      for (int r = 0; r < DEPTH; r++)
         for (int col = 0; col < COLS; col++) m_wr(col, r, 0);
      mh = 0; mv = 0; moff = 0;
      for (int r = 0; r < DEPTH; r++) mle[r] = 0;
   endfunction

   task automatic model_char(input logic [7:0] c, output int ecyc);
      int prow, stop;
      eq.delete();
      prow = (mv + moff) % DEPTH;
      case (c)
         8'h0D: begin
            mle[prow] = mh; mh = 0; m_newline();
         end
         8'h08: begin
            if (mh > 0) mh--;
            else if (mv > 0) begin
               mv--; prow = (mv + moff) % DEPTH; mh = mle[prow];
            end
            m_wr(mh, prow, 0);
         end
         8'h09: begin
            stop = (mh / TAB + 1) * TAB;
            for (int col = mh; col < stop && col < COLS; col++) m_wr(col, prow, 0);
            if (stop >= COLS) begin
               mle[prow] = COLS - 1; mh = 0; m_newline();
            end else mh = stop;
         end
         8'h0C: m_clear();
         default: begin
            m_wr(mh, prow, int'(c));
            if (mh == COLS - 1) begin
               mle[prow] = COLS - 1; mh = 0; m_newline();
            end else mh++;
         end
      endcase
      ecyc = eq.size() + 1 + ((c == 8'h0D || c == 8'h0C) ? 1 : 0);
   endtask

   task automatic cmp_writes(input string name);
      int bad = -1;
      int n = (gq.size() < eq.size()) ? gq.size() : eq.size();
      checks++;
      for (int i = 0; i < n; i++)
         if (bad < 0 && gq[i] != eq[i]) bad = i;
      if (bad < 0 && gq.size() != eq.size()) bad = n;
      if (bad >= 0) begin
         failures++;
         $display("FAIL %s: got %0d writes expected %0d, first diff at %0d (got %0h expected %0h)",
                  name, gq.size(), eq.size(), bad,
                  (bad < gq.size()) ? gq[bad] : -1, (bad < eq.size()) ? eq[bad] : -1);
      end
   endtask

   // Called at the negedge after acceptance; records writes until key_ready returns.
   task automatic collect(input int budget, output int cyc);
      cyc = 1;
      while (!key_ready && cyc <= budget) begin
         if (wr_en) gq.push_back(int'(wr_addr) * 256 + int'(wr_data));
         @(negedge clk_50m);
         cyc++;
      end
      if (!key_ready) begin
         checks++; failures++;
         $display("FAIL timeout: key_ready got 0 expected 1 within %0d cycles", budget);
      end
   endtask

   task automatic send(input logic [7:0] c, output int cyc);
      int guard = 0;
      while (!key_ready && guard < 5000) begin
         @(negedge clk_50m); guard++;
      end
      key_valid = 1'b1;
      key_char  = c;
      @(negedge clk_50m);
      key_valid = 1'b0;
      gq.delete();
      collect(NCLR + 200, cyc);
   endtask

   task automatic do_char(input logic [7:0] c, input string name);
      int ecyc;
      model_char(c, ecyc);
      send(c, last_cyc);
      cmp_writes({name, " writes"});
      chk({name, " cycles"}, last_cyc, ecyc);
      chk({name, " h_cur"}, int'(h_cur), mh);
      chk({name, " v_cur"}, int'(v_cur), mv);
      chk({name, " line_offset"}, int'(line_offset), moff);
   endtask

   task automatic release_reset(input string name);
      int cyc;
      BTNC = 1'b0;
      @(negedge clk_50m);
      eq.delete();
      m_clear();
      gq.delete();
      collect(NCLR + 200, cyc);
      cmp_writes({name, " writes"});
      chk({name, " cycles"}, cyc, NCLR + 1);
      chk({name, " h_cur"}, int'(h_cur), 0);
      chk({name, " v_cur"}, int'(v_cur), 0);
      chk({name, " line_offset"}, int'(line_offset), 0);
   endtask

   initial begin
      #1_800_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad, r;
      logic [7:0] c;

      //          ch     h  v  off nw    lcol lrow ldata
      vecs[0]  = '{8'h41,  1, 0, 0, 1,     0, 0, 8'h41};
      vecs[1]  = '{8'h09,  4, 0, 0, 3,     3, 0, 0};
      vecs[2]  = '{8'h08,  3, 0, 0, 1,     3, 0, 0};
      vecs[3]  = '{8'h0D,  0, 1, 0, 0,    -1, 0, 0};
      vecs[4]  = '{8'h08,  3, 0, 0, 1,     3, 0, 0};
      vecs[5]  = '{8'h61,  4, 0, 0, 1,     3, 0, 8'h61};
      vecs[6]  = '{8'h62,  5, 0, 0, 1,     4, 0, 8'h62};
      vecs[7]  = '{8'h0C,  0, 0, 0, NCLR, 69, 31, 0};
      vecs[8]  = '{8'h61,  1, 0, 0, 1,     0, 0, 8'h61};
      vecs[9]  = '{8'h62,  2, 0, 0, 1,     1, 0, 8'h62};
      vecs[10] = '{8'h0D,  0, 1, 0, 0,    -1, 0, 0};
      vecs[11] = '{8'h08,  2, 0, 0, 1,     2, 0, 0};
      vecs[12] = '{8'h08,  1, 0, 0, 1,     1, 0, 0};
      vecs[13] = '{8'h08,  0, 0, 0, 1,     0, 0, 0};
      vecs[14] = '{8'h08,  0, 0, 0, 1,     0, 0, 0};
      vecs[15] = '{8'h09,  4, 0, 0, 4,     3, 0, 0};

      // Reset state
      BTNC = 1'b1;
      repeat (3) @(negedge clk_50m);
      chk("rst wr_en", int'(wr_en), 0);
      chk("rst wr_addr", int'(wr_addr), 0);
      chk("rst wr_data", int'(wr_data), 0);
      chk("rst key_ready", int'(key_ready), 0);
      chk("rst h_cur", int'(h_cur), 0);
      chk("rst v_cur", int'(v_cur), 0);
      chk("rst line_offset", int'(line_offset), 0);
      release_reset("boot clear");

      // Hand-computed vector table
      for (int i = 0; i < 16; i++) begin
         do_char(vecs[i].ch, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d tbl h", i), int'(h_cur), vecs[i].h);
         chk($sformatf("vec%0d tbl v", i), int'(v_cur), vecs[i].v);
         chk($sformatf("vec%0d tbl off", i), int'(line_offset), vecs[i].off);
         chk($sformatf("vec%0d tbl nw", i), gq.size(), vecs[i].nw);
         if (vecs[i].lcol >= 0)
            chk($sformatf("vec%0d tbl last", i), (gq.size() > 0) ? gq[$] : -1,
                wcode(vecs[i].lcol, vecs[i].lrow, vecs[i].ldata));
         if (i == 0) chk("A ready latency", last_cyc, 2);
      end

      // Full line of printables wraps to the next row
      do_char(8'h0C, "clr1");
      for (int i = 0; i < COLS; i++) begin
         c = 8'h61 + 8'(i % 26);
         do_char(c, $sformatf("line%0d", i));
      end
      chk("wrap last write", (gq.size() > 0) ? gq[$] : -1, wcode(69, 0, int'(c)));
      chk("wrap h", int'(h_cur), 0);
      chk("wrap v", int'(v_cur), 1);
      do_char(8'h08, "bs after wrap");
      chk("bs line_end h", int'(h_cur), 69);
      chk("bs line_end v", int'(v_cur), 0);
      chk("bs line_end write", (gq.size() > 0) ? gq[0] : -1, wcode(69, 0, 0));

      // Thirty enters scroll once and clear the new bottom row
      do_char(8'h0C, "clr2");
      for (int i = 0; i < ROWS; i++) do_char(8'h0D, $sformatf("enter%0d", i));
      chk("scroll offset", int'(line_offset), 1);
      chk("scroll v", int'(v_cur), 29);
      chk("scroll nw", gq.size(), COLS);
      bad = 0;
      foreach (gq[i]) if (((gq[i] >> 8) & (DEPTH - 1)) != 30 || (gq[i] & 255) != 0) bad++;
      chk("scroll row30 zero writes", bad, 0);
      chk("scroll busy cycles", last_cyc, COLS + 2);

      // Reset in the middle of a row clear
      key_valid = 1'b1; key_char = 8'h0D;
      @(negedge clk_50m);
      key_valid = 1'b0;
      repeat (10) @(negedge clk_50m);
      chk("mid clr_row wr_en", int'(wr_en), 1);
      BTNC = 1'b1;
      @(negedge clk_50m);
      chk("abort wr_en", int'(wr_en), 0);
      chk("abort h", int'(h_cur), 0);
      chk("abort v", int'(v_cur), 0);
      chk("abort off", int'(line_offset), 0);
      chk("abort key_ready", int'(key_ready), 0);
      @(negedge clk_50m);
      chk("abort hold wr_en", int'(wr_en), 0);
      release_reset("post-abort clear");

      // Random keystrokes against the model
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 999));
         if (r < 600)      c = 8'($urandom_range(32, 126));
         else if (r < 730) c = 8'h0D;
         else if (r < 850) c = 8'h08;
         else if (r < 970) c = 8'h09;
         else if (r < 978) c = 8'h0C;
         else              c = 8'($urandom_range(0, 255));
         repeat ($urandom_range(0, 2)) @(negedge clk_50m);
         do_char(c, $sformatf("rnd%0d(%0h)", i, c));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/text_console_ctrl.md
TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 70, visible text columns.
REQ-002 SHALL have parameter ROWS, default 30, visible text rows.
REQ-003 SHALL have parameter CW, default 7, column index width; RW, default 5, row index width; buffer depth 2^RW rows, and 2^RW SHALL be greater than ROWS.
REQ-004 SHALL have parameter TAB, default 4, tab stop spacing in columns (power of 2).
REQ-005 SHALL have port clk_50m, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port BTNC, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port key_valid, input, 1, character offered.
REQ-008 SHALL have port key_char, input, 8, ASCII code: 0x08 backspace, 0x0D enter, 0x09 tab, 0x0C clear screen, others printable.
REQ-009 SHALL have port key_ready, output, 1, high when the block can accept a character.
REQ-010 SHALL have port wr_en, output, 1, character buffer write strobe.
REQ-011 SHALL have port wr_addr, output, CW+RW, buffer address {col, physical row}.
REQ-012 SHALL have port wr_data, output, 8, byte to write.
REQ-013 SHALL have ports h_cur (CW) and v_cur (RW), outputs, cursor column and visible row.
REQ-014 SHALL have port line_offset, output, RW, physical row shown at visible row 0; reader address = {col, v + line_offset} mod 2^RW.

Function
REQ-015 A character SHALL be accepted only on a cycle with key_valid and key_ready both high; key_ready SHALL be low in every state except IDLE.
REQ-016 State machine SHALL have four states: IDLE, EXEC (one cycle), CLR_ROW, CLR_ALL; an accepted character moves IDLE->EXEC.
REQ-017 For a printable character in EXEC: wr_en=1, wr_addr={h_cur, v_cur+line_offset}, wr_data=key_char; h_cur increments.
REQ-018 After writing at column COLS-1, h_cur SHALL become 0, line_end[row] SHALL record COLS-1, and the block SHALL perform a newline.
REQ-019 Enter SHALL record line_end[row]=h_cur, set h_cur=0, perform a newline, and issue no character write.
REQ-020 Newline with v_cur<ROWS-1 SHALL increment v_cur and return to IDLE.
REQ-021 Newline with v_cur=ROWS-1 SHALL increment line_offset mod 2^RW, keep v_cur, and enter CLR_ROW.
REQ-022 CLR_ROW SHALL write 0x00 to cols 0..COLS-1 of the new bottom physical row, one per cycle (COLS cycles), clear that row's line_end to 0, then return to IDLE.
REQ-023 Tab SHALL write 0x00 from h_cur up to the next multiple of TAB, one column per cycle, and advance h_cur; reaching COLS SHALL behave as a wrap (REQ-018).
REQ-024 Backspace with h_cur>0 SHALL decrement h_cur and write 0x00 at the new position.
REQ-025 Backspace with h_cur=0 and v_cur>0 SHALL set v_cur-1, set h_cur=line_end[that row], and write 0x00 there.
REQ-026 Backspace at (0,0) SHALL write 0x00 at (0,0), and the cursor and offset SHALL stay unchanged.
REQ-027 Clear screen (0x0C) SHALL enter CLR_ALL, write 0x00 to every address (COLS x 2^RW cycles, row-major), zero all line_end entries, set h_cur=v_cur=line_offset=0, then return to IDLE.
REQ-028 wr_en SHALL be high only in EXEC (printable/backspace), tab fill, CLR_ROW and CLR_ALL, and exactly one write SHALL occur per high cycle.
REQ-029 All row arithmetic SHALL wrap modulo 2^RW, and column arithmetic SHALL never exceed COLS-1 on wr_addr.
REQ-030 line_end SHALL be a 2^RW x CW register array indexed by physical row.

Reset
REQ-031 BTNC high on any clock edge SHALL abort any state, go to IDLE, and set h_cur=0, v_cur=0, line_offset=0, wr_en=0, wr_addr=0, wr_data=0, key_ready=0.
REQ-032 In the cycle after BTNC deasserts, the block SHALL enter CLR_ALL; key_ready SHALL rise only when CLR_ALL completes.
REQ-033 BTNC asserted in the middle of CLR_ROW or tab fill SHALL leave no further writes until the post-reset CLR_ALL.

Verification
REQ-034 Send 'A' (0x41) after the post-reset clear -> one write {0,0}=0x41, then h_cur=1 and key_ready high again 2 cycles after acceptance.
REQ-035 Send 70 printables -> last write at {69,0}, then h_cur=0, v_cur=1, line_end[0]=69.
REQ-036 Send 30 enters -> line_offset=1, v_cur=29, 70 zero writes to physical row 30, and key_ready low for those 70 cycles.
REQ-037 Send 'ab', enter, backspace -> cursor (2,0), write 0x00 at {2,0}; then backspace at (0,0) -> no cursor move.
REQ-038 At h_cur=1 send tab -> zero writes at cols 1,2,3, h_cur=4; send clear screen -> 70x32 writes, then cursor and offset 0.
REQ-039 Assert BTNC mid-CLR_ROW -> wr_en low the next cycle, cursor and offset 0, followed by a full CLR_ALL.
